// File: rtl/hud_border_overlay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hud_border_overlay_pkg
//  Description : Shared blink-state encodings and BCD to 7-segment mapping
//                for the HUD border/timer compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
package hud_border_overlay_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_on   = 2'd1;
    localparam logic [1:0] c_st_off  = 2'd2;

    // Segment order {a,b,c,d,e,f,g}; non-decimal codes light nothing.
    function automatic logic [6:0] seg_map(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_map = 7'b1111110;
            4'd1:    seg_map = 7'b0110000;
            4'd2:    seg_map = 7'b1101101;
            4'd3:    seg_map = 7'b1111001;
            4'd4:    seg_map = 7'b0110011;
            4'd5:    seg_map = 7'b1011011;
            4'd6:    seg_map = 7'b1011111;
            4'd7:    seg_map = 7'b1110000;
            4'd8:    seg_map = 7'b1111111;
            4'd9:    seg_map = 7'b1111011;
            default: seg_map = 7'b0000000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hud_border_overlay_seg7_glyph.sv
`default_nettype none
// ============================================================================
//  Module      : hud_border_overlay_seg7_glyph
//  Description : Combinational 16x16 seven-segment glyph pixel lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module hud_border_overlay_seg7_glyph
    import hud_border_overlay_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic [3:0] i_lx,
    input  logic [3:0] i_ly,
    output logic       o_lit
);

    logic [6:0] w_seg;
    logic       w_mid_x;
    logic       w_left_x;
    logic       w_right_x;
    logic       w_upper_y;
    logic       w_lower_y;
    logic       w_a, w_b, w_c, w_d, w_e, w_f, w_g;

    assign w_seg     = seg_map(i_bcd);
    assign w_mid_x   = (i_lx >= 4'd3)  && (i_lx <= 4'd12);
    assign w_left_x  = (i_lx >= 4'd1)  && (i_lx <= 4'd2);
    assign w_right_x = (i_lx >= 4'd13) && (i_lx <= 4'd14);
    assign w_upper_y = (i_ly >= 4'd3)  && (i_ly <= 4'd6);
    assign w_lower_y = (i_ly >= 4'd9)  && (i_ly <= 4'd12);

    assign w_a = w_seg[6] && w_mid_x   && ((i_ly == 4'd1)  || (i_ly == 4'd2));
    assign w_b = w_seg[5] && w_right_x && w_upper_y;
    assign w_c = w_seg[4] && w_right_x && w_lower_y;
    assign w_d = w_seg[3] && w_mid_x   && ((i_ly == 4'd13) || (i_ly == 4'd14));
    assign w_e = w_seg[2] && w_left_x  && w_lower_y;
    assign w_f = w_seg[1] && w_left_x  && w_upper_y;
    assign w_g = w_seg[0] && w_mid_x   && ((i_ly == 4'd7)  || (i_ly == 4'd8));

    assign o_lit = w_a || w_b || w_c || w_d || w_e || w_f || w_g;

endmodule
`default_nettype wire

// File: rtl/hud_border_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : hud_border_overlay
//  Description : 2-stage compositor drawing a border frame and a blinking
//                N-digit BCD timer over the game pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module hud_border_overlay
    import hud_border_overlay_pkg::*;
#(
    parameter int          H_ACTIVE      = 640,
    parameter int          V_ACTIVE      = 480,
    parameter int          BORDER_W      = 16,
    parameter int          NUM_DIGITS    = 3,
    parameter int          DIGIT_SCALE   = 1,
    parameter int          LZ_BLANK      = 1,
    parameter int          BLINK_FRAMES  = 30,
    parameter logic [15:0] BORDER_COLOUR = 16'h4040,
    parameter logic [15:0] DIGIT_FG      = 16'hFFFF,
    parameter logic [15:0] ALERT_FG      = 16'hF800,
    parameter logic [15:0] DIGIT_BG      = 16'h0000
) (
    input  logic                    vga_clk,
    input  logic                    sys_rst_n,
    input  logic [9:0]              pix_x,
    input  logic [9:0]              pix_y,
    input  logic                    pix_valid,
    input  logic [15:0]             pix_in_data,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic                    alert,
    output logic [15:0]             pix_data,
    output logic                    pix_data_valid
);

    localparam int c_cw    = 16 * DIGIT_SCALE;
    localparam int c_sh    = $clog2(DIGIT_SCALE);
    localparam int c_tl    = (H_ACTIVE - NUM_DIGITS * c_cw) / 2;
    localparam int c_cnt_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]        c_box_x0   = 11'(c_tl);
    localparam logic [10:0]        c_box_x1   = 11'(c_tl + NUM_DIGITS * c_cw);
    localparam logic [10:0]        c_box_y0   = 11'(V_ACTIVE - c_cw);
    localparam logic [10:0]        c_box_y1   = 11'(V_ACTIVE);
    localparam logic [10:0]        c_bdr_lo   = 11'(BORDER_W);
    localparam logic [10:0]        c_bdr_r    = 11'(H_ACTIVE - BORDER_W);
    localparam logic [10:0]        c_bdr_b    = 11'(V_ACTIVE - BORDER_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLINK_FRAMES - 1);

    logic [10:0]             w_x, w_y, w_dx, w_dy;
    logic                    w_in_box, w_in_border;
    logic [2:0]              w_k, w_dig_idx;
    logic [3:0]              w_lx, w_ly;
    logic [3:0]              w_sel_bcd, w_s1_bcd;
    logic                    w_lead, w_blank;
    logic                    w_lit;
    logic [15:0]             w_pix;

    logic [4*NUM_DIGITS-1:0] r_snap;
    logic [1:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_s1_box, r_s1_border, r_s1_valid;
    logic [3:0]              r_s1_bcd, r_s1_lx, r_s1_ly;
    logic [15:0]             r_s1_data;

    // Stage 1: region decode and local glyph coordinates.
    assign w_x         = {1'b0, pix_x};
    assign w_y         = {1'b0, pix_y};
    assign w_in_box    = (w_x >= c_box_x0) && (w_x < c_box_x1) &&
                         (w_y >= c_box_y0) && (w_y < c_box_y1);
    assign w_in_border = (w_x < c_bdr_lo) || (w_x >= c_bdr_r) ||
                         (w_y < c_bdr_lo) || (w_y >= c_bdr_b);
    assign w_dx        = w_x - c_box_x0;
    assign w_dy        = w_y - c_box_y0;
    assign w_k         = 3'(w_dx >> (4 + c_sh));
    assign w_dig_idx   = 3'(NUM_DIGITS - 1) - w_k;
    assign w_lx        = 4'(w_dx >> c_sh);
    assign w_ly        = 4'(w_dy >> c_sh);

    // Digit value is taken from the snapshot here, not in stage 2, so a pixel
    // coincident with frame_start still sees the previous frame's digits.
    always_comb begin
        w_sel_bcd = 4'd0;
        w_blank   = 1'b0;
        w_lead    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_lead = w_lead && (r_snap[4*i +: 4] == 4'd0);
            if (w_dig_idx == 3'(i)) begin
                w_sel_bcd = r_snap[4*i +: 4];
                w_blank   = (LZ_BLANK != 0) && (i != 0) && w_lead;
            end
        end
    end

    assign w_s1_bcd = w_blank ? 4'hF : w_sel_bcd;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1_box    <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_bcd    <= 4'd0;
            r_s1_lx     <= 4'd0;
            r_s1_ly     <= 4'd0;
            r_s1_data   <= 16'd0;
        end else begin
            r_s1_box    <= w_in_box;
            r_s1_border <= w_in_border;
            r_s1_valid  <= pix_valid;
            r_s1_bcd    <= w_s1_bcd;
            r_s1_lx     <= w_lx;
            r_s1_ly     <= w_ly;
            r_s1_data   <= pix_in_data;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_snap  <= '0;
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else if (frame_start) begin
            r_snap <= digits_bcd;
            case (r_state)
                c_st_idle: begin
                    if (alert) begin
                        r_state <= c_st_on;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (!alert) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= (r_state == c_st_on) ? c_st_off : c_st_on;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage 2: glyph lookup and colour priority mux.
    hud_border_overlay_seg7_glyph u_glyph (
        .i_bcd (r_s1_bcd),
        .i_lx  (r_s1_lx),
        .i_ly  (r_s1_ly),
        .o_lit (w_lit)
    );

    always_comb begin
        w_pix = r_s1_data;
        if (r_s1_box) begin
            w_pix = DIGIT_BG;
            if (w_lit) begin
                case (r_state)
                    c_st_on:  w_pix = ALERT_FG;
                    c_st_off: w_pix = DIGIT_BG;
                    default:  w_pix = DIGIT_FG;
                endcase
            end
        end else if (r_s1_border) begin
            w_pix = BORDER_COLOUR;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data       <= 16'd0;
            pix_data_valid <= 1'b0;
        end else begin
            pix_data       <= w_pix;
            pix_data_valid <= r_s1_valid;
        end
    end

endmodule
`default_nettype wire
